// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO read-port arbiter.
// Round-robin search is written for up to 16 consumers; callers zero-pad narrower request vectors.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int BURST_CNT_W = 8;
    localparam int MAX_REQ     = 16;
    localparam int REQ_IDX_W   = 4;

    // First set request at or after ptr, wrapping at num; returns ptr when nothing is set.
    function automatic logic [REQ_IDX_W-1:0] rr_next(
        input logic [MAX_REQ-1:0]   req,
        input logic [REQ_IDX_W-1:0] ptr,
        input int                   num
    );
        logic [REQ_IDX_W-1:0] pick;
        logic                 found;
        int                   idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % num;
            if (!found && (i < num) && req[idx[REQ_IDX_W-1:0]]) begin
                pick  = idx[REQ_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational circular first-one search starting at ptr, with a valid flag when any request is set.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] gnt,
    output logic                       valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [MAX_REQ-1:0] req_ext;

    generate
        for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_req_ext
            if (gi < NUM_REQ) begin : g_live
                assign req_ext[gi] = req[gi];
            end else begin : g_pad
                assign req_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign gnt   = IDX_W'(rr_next(req_ext, REQ_IDX_W'(ptr), NUM_REQ));
    assign valid = |req;

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin sharing of an async FIFO read port among NUM_REQ consumers, bursts of up to a limit per grant.
// Optional FIFO_ARB_WEIGHT_EN adds a per-consumer burst weight input (cfg_weight).
module fifo_read_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       rclk,
    input  logic                       rrst,
    input  logic                       fifo_rempty,
    input  logic [DATA_SIZE-1:0]       fifo_rdata,
    output logic                       fifo_rinc,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         out_ready,
`ifdef FIFO_ARB_WEIGHT_EN
    input  logic [NUM_REQ*8-1:0]       cfg_weight,
`endif
    output logic                       out_valid,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic [DATA_SIZE-1:0]       out_data,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t             state_reg,     state_next;
    logic [ID_W-1:0]        gnt_reg,       gnt_next;
    logic [ID_W-1:0]        ptr_reg,       ptr_next;
    logic [BURST_CNT_W-1:0] count_reg,     count_next;
    logic [BURST_CNT_W-1:0] limit_reg,     limit_next;
    logic                   out_valid_reg, out_valid_next;
    logic [ID_W-1:0]        out_id_reg,    out_id_next;
    logic [DATA_SIZE-1:0]   out_data_reg,  out_data_next;

    logic                   pick_valid;
    logic [ID_W-1:0]        pick_gnt;
    logic [BURST_CNT_W-1:0] pick_limit;
    logic                   pop_now;
    logic                   xfer;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_reg),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

`ifdef FIFO_ARB_WEIGHT_EN
    logic [BURST_CNT_W-1:0] weight_sel;
    assign weight_sel = cfg_weight[pick_gnt*BURST_CNT_W +: BURST_CNT_W];
    // A zero weight would otherwise never terminate on count, so it behaves as one.
    assign pick_limit = (weight_sel == '0) ? BURST_CNT_W'(1) : weight_sel;
`else
    assign pick_limit = BURST_CNT_W'(MAX_BURST);
`endif

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            ptr_reg       <= '0;
            count_reg     <= '0;
            limit_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_id_reg    <= '0;
            out_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            ptr_reg       <= ptr_next;
            count_reg     <= count_next;
            limit_reg     <= limit_next;
            out_valid_reg <= out_valid_next;
            out_id_reg    <= out_id_next;
            out_data_reg  <= out_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        ptr_next       = ptr_reg;
        count_next     = count_reg;
        limit_next     = limit_reg;
        out_valid_next = out_valid_reg;
        out_id_next    = out_id_reg;
        out_data_next  = out_data_reg;
        pop_now        = 1'b0;
        xfer           = out_valid_reg && out_ready[out_id_reg];

        if (xfer) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = BURST;
                    gnt_next   = pick_gnt;
                    count_next = '0;
                    limit_next = pick_limit;
                end
            end
            BURST: begin
                // Pop only when the output slot is free or being emptied this cycle.
                pop_now = !fifo_rempty && req[gnt_reg] && (!out_valid_reg || out_ready[gnt_reg]);
                if (pop_now) begin
                    out_data_next  = fifo_rdata;
                    out_id_next    = gnt_reg;
                    out_valid_next = 1'b1;
                    count_next     = count_reg + BURST_CNT_W'(1);
                end
                if ((pop_now && ((count_reg + BURST_CNT_W'(1)) == limit_reg)) ||
                    fifo_rempty || !req[gnt_reg]) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid_reg || xfer) begin
                    state_next = IDLE;
                    ptr_next   = (gnt_reg == ID_W'(NUM_REQ - 1)) ? '0 : (gnt_reg + ID_W'(1));
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign fifo_rinc = pop_now && !rrst;
    assign out_valid = out_valid_reg;
    assign out_id    = out_id_reg;
    assign out_data  = out_data_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Self-checking bench for fifo_read_arbiter: behavioural FIFO model plus {id,data} scoreboard.
`timescale 1ns/1ps
module tb_fifo_read_arbiter;

    localparam int DATA_SIZE = 8;
    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 4;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       fifo_rempty;
    logic [7:0] fifo_rdata;
    logic       fifo_rinc;
    logic [3:0] req;
    logic [3:0] out_ready;
    logic       out_valid;
    logic [1:0] out_id;
    logic [7:0] out_data;
    logic       busy;
`ifdef FIFO_ARB_WEIGHT_EN
    logic [31:0] cfg_weight;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fifo_q[$];
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    int         burst_q[$];
    int         pops_total;
    int         cur_burst;
    int         overreads;
    logic       busy_prev;
    logic       hold_empty;

    fifo_read_arbiter #(
        .DATA_SIZE (DATA_SIZE),
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .rclk        (rclk),
        .rrst        (rrst),
        .fifo_rempty (fifo_rempty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rinc   (fifo_rinc),
        .req         (req),
        .out_ready   (out_ready),
`ifdef FIFO_ARB_WEIGHT_EN
        .cfg_weight  (cfg_weight),
`endif
        .out_valid   (out_valid),
        .out_id      (out_id),
        .out_data    (out_data),
        .busy        (busy)
    );

    always #5 rclk = ~rclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic refresh_fifo();
        fifo_rempty = hold_empty || (fifo_q.size() == 0);
        fifo_rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    // Samples at the negedge, lets the active edge pass, then updates the FIFO model.
    task automatic tick();
        logic rinc_s;
        @(negedge rclk);
        rinc_s = fifo_rinc;
        if (fifo_rinc) begin
            pops_total++;
            cur_burst++;
            if (fifo_rempty) overreads++;
        end
        if (out_valid && out_ready[out_id]) obs_q.push_back({out_id, out_data});
        if (busy_prev && !busy) begin
            burst_q.push_back(cur_burst);
            cur_burst = 0;
        end
        busy_prev = busy;
        @(posedge rclk);
        #1;
        if (rinc_s && fifo_q.size() > 0) fifo_q.delete(0);
        refresh_fifo();
    endtask

    task automatic push_word(input logic [1:0] id, input logic [7:0] d);
        fifo_q.push_back(d);
        exp_q.push_back({id, d});
        refresh_fifo();
    endtask

    task automatic reset_dut();
        rrst       = 1'b1;
        req        = '0;
        out_ready  = '1;
        hold_empty = 1'b0;
        fifo_q.delete();
        refresh_fifo();
        tick();
        tick();
        rrst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        burst_q.delete();
        pops_total = 0;
        cur_burst  = 0;
        overreads  = 0;
        busy_prev  = 1'b0;
    endtask

    task automatic settle(output bit ok);
        ok  = 1'b0;
        req = '0;
        for (int c = 0; c < 50 && !ok; c++) begin
            tick();
            if (!busy && !out_valid) ok = 1'b1;
        end
        tick();
    endtask

    task automatic test_reset();
        rrst       = 1'b1;
        req        = 4'hF;
        out_ready  = 4'hF;
        hold_empty = 1'b0;
        for (int i = 0; i < 3; i++) fifo_q.push_back(8'hA0 + 8'(i));
        refresh_fifo();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (fifo_rinc !== 1'b0) begin n_fail++; $display("FAIL reset_rinc: cycle %0d got %b required 0", c, fifo_rinc); end
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: cycle %0d got %b required 0", c, out_valid); end
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: cycle %0d got %b required 0", c, busy); end
        end
        n_checks++;
        if (out_id !== 2'd0 || out_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_outputs: got id=%0d data=%02h required id=0 data=00", out_id, out_data);
        end
        rrst = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_release_busy: got %b required 1", busy); end
        n_checks++;
        if (fifo_rinc !== 1'b1) begin n_fail++; $display("FAIL reset_release_pop: got %b required 1", fifo_rinc); end
        $display("reset test done");
    endtask

    task automatic test_single();
        logic [9:0] got, want;
        bit ok;
        reset_dut();
        for (int i = 0; i < 6; i++) push_word(2'd0, 8'h11 + 8'(i));
        req = 4'b0001;
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            tick();
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                got  = obs_q.pop_front();
                want = exp_q.pop_front();
                n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL single_word: got id=%0d data=%02h required id=%0d data=%02h", got[9:8], got[7:0], want[9:8], want[7:0]); end
                else $display("single xfer id=%0d data=%02h", got[9:8], got[7:0]);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_timeout: %0d words outstanding, required 0", exp_q.size()); end
        settle(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_settle: busy=%b required 0", busy); end
        n_checks++;
        if (burst_q.size() < 2) begin
            n_fail++; $display("FAIL single_bursts: got %0d bursts required at least 2", burst_q.size());
        end else if (burst_q[0] !== 4 || burst_q[1] !== 2) begin
            n_fail++; $display("FAIL single_bursts: got sizes %0d,%0d required 4,2", burst_q[0], burst_q[1]);
        end
    endtask

    task automatic test_round_robin();
        logic [9:0] got, want;
        bit ok;
        reset_dut();
        for (int i = 0; i < 16; i++) push_word(2'(i / 4), 8'h20 + 8'(i));
        req = 4'hF;
        for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
            tick();
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                got  = obs_q.pop_front();
                want = exp_q.pop_front();
                n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL rr_word: got id=%0d data=%02h required id=%0d data=%02h", got[9:8], got[7:0], want[9:8], want[7:0]); end
                else $display("rr xfer id=%0d data=%02h", got[9:8], got[7:0]);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_timeout: %0d words outstanding, required 0", exp_q.size()); end
        settle(ok);
        n_checks++;
        if (!ok || obs_q.size() != 0) begin n_fail++; $display("FAIL rr_extra: settled=%b extra words=%0d required 1,0", ok, obs_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [9:0] got, want;
        logic [7:0] held_data;
        logic [1:0] held_id;
        bit ok;
        reset_dut();
        for (int i = 0; i < 4; i++) push_word(2'd1, 8'h41 + 8'(i));
        req = 4'b0010;
        for (int c = 0; c < 20 && !out_valid; c++) tick();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_start: out_valid got %b required 1", out_valid); end
        held_data = out_data;
        held_id   = out_id;
        out_ready = 4'b1101;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held_data || out_id !== held_id) begin
                n_fail++; $display("FAIL bp_hold: got v=%b id=%0d data=%02h required v=1 id=%0d data=%02h", out_valid, out_id, out_data, held_id, held_data);
            end
            n_checks++;
            if (fifo_rinc !== 1'b0) begin n_fail++; $display("FAIL bp_rinc: got %b required 0", fifo_rinc); end
        end
        out_ready = 4'hF;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            tick();
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                got  = obs_q.pop_front();
                want = exp_q.pop_front();
                n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL bp_word: got id=%0d data=%02h required id=%0d data=%02h", got[9:8], got[7:0], want[9:8], want[7:0]); end
                else $display("bp xfer id=%0d data=%02h", got[9:8], got[7:0]);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_timeout: %0d words outstanding, required 0", exp_q.size()); end
        settle(ok);
        n_checks++;
        if (!ok || obs_q.size() != 0 || overreads != 0) begin
            n_fail++; $display("FAIL bp_extra: settled=%b extra=%0d overreads=%0d required 1,0,0", ok, obs_q.size(), overreads);
        end
    endtask

    task automatic test_empty_mid();
        logic [9:0] got, want;
        bit ok;
        reset_dut();
        push_word(2'd0, 8'h61);
        push_word(2'd0, 8'h62);
        for (int i = 0; i < 4; i++) push_word(2'd2, 8'h63 + 8'(i));
        req = 4'b0101;
        for (int c = 0; c < 20 && pops_total < 2; c++) tick();
        n_checks++;
        if (pops_total != 2) begin n_fail++; $display("FAIL empty_pops: got %0d required 2", pops_total); end
        hold_empty = 1'b1;
        refresh_fifo();
        tick();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL empty_drain_busy: got %b required 1", busy); end
        hold_empty = 1'b0;
        refresh_fifo();
        n_checks++;
        if (fifo_rinc !== 1'b0) begin n_fail++; $display("FAIL empty_late_pop: got %b required 0", fifo_rinc); end
        tick();
        n_checks++;
        if (busy !== 1'b0 || fifo_rinc !== 1'b0) begin n_fail++; $display("FAIL empty_idle: got busy=%b rinc=%b required 0,0", busy, fifo_rinc); end
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            tick();
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                got  = obs_q.pop_front();
                want = exp_q.pop_front();
                n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL empty_word: got id=%0d data=%02h required id=%0d data=%02h", got[9:8], got[7:0], want[9:8], want[7:0]); end
                else $display("empty xfer id=%0d data=%02h", got[9:8], got[7:0]);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL empty_timeout: %0d words outstanding, required 0", exp_q.size()); end
        settle(ok);
        n_checks++;
        if (!ok || obs_q.size() != 0 || overreads != 0) begin
            n_fail++; $display("FAIL empty_extra: settled=%b extra=%0d overreads=%0d required 1,0,0", ok, obs_q.size(), overreads);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [9:0] got, want;
        bit ok;
        reset_dut();
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'h71 + 8'(i));
        refresh_fifo();
        req = 4'b0001;
        for (int c = 0; c < 20 && !out_valid; c++) tick();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_start: out_valid got %b required 1", out_valid); end
        #2;
        rrst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 || fifo_rinc !== 1'b0) begin
            n_fail++; $display("FAIL midrst_async: got v=%b data=%02h busy=%b rinc=%b required 0,00,0,0", out_valid, out_data, busy, fifo_rinc);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (fifo_rinc !== 1'b0) begin n_fail++; $display("FAIL midrst_rinc: got %b required 0", fifo_rinc); end
        end
        rrst = 1'b0;
        busy_prev = 1'b0;
        obs_q.delete();
        for (int i = 1; i < 4; i++) exp_q.push_back({2'd0, 8'h71 + 8'(i)});
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            tick();
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                got  = obs_q.pop_front();
                want = exp_q.pop_front();
                n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL midrst_word: got id=%0d data=%02h required id=%0d data=%02h", got[9:8], got[7:0], want[9:8], want[7:0]); end
                else $display("midrst xfer id=%0d data=%02h", got[9:8], got[7:0]);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_timeout: %0d words outstanding, required 0", exp_q.size()); end
        settle(ok);
        n_checks++;
        if (!ok || obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_extra: settled=%b extra=%0d required 1,0", ok, obs_q.size()); end
    endtask

`ifdef FIFO_ARB_WEIGHT_EN
    task automatic test_weight();
        logic [9:0] got, want;
        bit ok;
        reset_dut();
        cfg_weight = {8'd0, 8'd3, 8'd1, 8'd2};
        push_word(2'd0, 8'h81);
        push_word(2'd0, 8'h82);
        push_word(2'd1, 8'h83);
        push_word(2'd2, 8'h84);
        push_word(2'd2, 8'h85);
        push_word(2'd2, 8'h86);
        push_word(2'd3, 8'h87);
        req = 4'hF;
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            tick();
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                got  = obs_q.pop_front();
                want = exp_q.pop_front();
                n_checks++;
                if (got !== want) begin n_fail++; $display("FAIL weight_word: got id=%0d data=%02h required id=%0d data=%02h", got[9:8], got[7:0], want[9:8], want[7:0]); end
                else $display("weight xfer id=%0d data=%02h", got[9:8], got[7:0]);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL weight_timeout: %0d words outstanding, required 0", exp_q.size()); end
        settle(ok);
        n_checks++;
        if (burst_q.size() < 4) begin
            n_fail++; $display("FAIL weight_bursts: got %0d bursts required at least 4", burst_q.size());
        end else if (burst_q[0] !== 2 || burst_q[1] !== 1 || burst_q[2] !== 3 || burst_q[3] !== 1) begin
            n_fail++; $display("FAIL weight_bursts: got %0d,%0d,%0d,%0d required 2,1,3,1", burst_q[0], burst_q[1], burst_q[2], burst_q[3]);
        end
        cfg_weight = {4{8'd4}};
    endtask
`endif

    initial begin
        rrst       = 1'b1;
        req        = '0;
        out_ready  = '1;
        hold_empty = 1'b0;
        pops_total = 0;
        cur_burst  = 0;
        overreads  = 0;
        busy_prev  = 1'b0;
`ifdef FIFO_ARB_WEIGHT_EN
        cfg_weight = {4{8'd4}};
`endif
        refresh_fifo();

        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_empty_mid();
        test_reset_mid_burst();
`ifdef FIFO_ARB_WEIGHT_EN
        test_weight();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
